// File: rtl/cache_pkg.sv
// Shared types and address helpers for the 2-way write-through data cache.
// Used by the miss/refill sequencer and by the cache array.
package cache_pkg;

  localparam int NUM_WAY = 2;

  typedef logic [$clog2(NUM_WAY)-1:0] way_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_MISS,
    FILL,
    WR_MEM,
    DONE
  } ctrl_state_t;

  // Lines are one word, so the set index sits directly above the byte offset.
  function automatic logic [31:0] set_index(input logic [31:0] addr, input int set_w);
    return (addr >> 2) & ((32'd1 << set_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int set_w);
    return addr >> (2 + set_w);
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cache_if.sv
// Main-memory req/ready bus between the cache sequencer (master) and memory (slave).
interface cache_if;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/cache_lru.sv
// Per-set LRU bits for a 2-way cache plus the victim-way choice for the addressed set.
module cache_lru
  import cache_pkg::*;
#(
  parameter  int NUM_SET = 4,
  localparam int SET_W   = $clog2(NUM_SET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SET_W-1:0] lookup_set,
  input  logic             valid0,
  input  logic             valid1,
  output way_t             victim,
  input  logic             upd_en,
  input  logic [SET_W-1:0] upd_set,
  input  way_t             upd_way
);

  logic [NUM_SET-1:0] lru;

  // NOTE: lru is a small flop array rather than a RAM, so it can take the
  // async reset; after reset every set must prefer way 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lru <= '0;
    end else if (upd_en) begin
      lru[upd_set] <= ~upd_way;
    end
  end

  // An empty way is always refilled before anything live gets evicted.
  always_comb begin
    if (!valid0)      victim = 1'b0;
    else if (!valid1) victim = 1'b1;
    else              victim = lru[lookup_set];
  end

endmodule

// File: rtl/cache_ctrl.sv
// Miss/refill and write-through sequencer for the 2-way data cache: stalls the
// pipeline on read misses and stores, talks to memory, and strobes the cache arrays.
module cache_ctrl
  import cache_pkg::*;
#(
  parameter  int NUM_SET = 4,
  localparam int SET_W   = $clog2(NUM_SET)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic [31:0]      ALUResultM,
  input  logic [31:0]      WriteDataM,
  input  logic             Hit0,
  input  logic             Hit1,
  input  logic             Valid0,
  input  logic             Valid1,
  output logic             StallM,
  output logic             FillEn,
  output logic             UpdateEn,
  output logic             CacheWay,
  output logic [SET_W-1:0] CacheSet,
  output logic [31:0]      CacheData,
  cache_if.master          mem
);

  ctrl_state_t      state, state_next;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic             hit0_q, hit1_q;
  way_t             victim, victim_q;
  logic             stall;
  logic             lru_upd;
  logic [SET_W-1:0] lru_set;
  way_t             lru_way;
  logic [SET_W-1:0] set_in, set_q;
  logic             start_wr, start_rd, req_next;

  assign set_in   = SET_W'(set_index(ALUResultM, SET_W));
  assign set_q    = SET_W'(set_index(addr_q, SET_W));
  assign start_wr = (state == IDLE) && MemWriteM;
  assign start_rd = (state == IDLE) && !MemWriteM && MemReadM && !(Hit0 || Hit1);
  assign req_next = (state_next == RD_MISS) || (state_next == WR_MEM);

  cache_lru #(.NUM_SET(NUM_SET)) u_lru (
    .clk        (clk),
    .rst        (rst),
    .lookup_set (set_in),
    .valid0     (Valid0),
    .valid1     (Valid1),
    .victim     (victim),
    .upd_en     (lru_upd),
    .upd_set    (lru_set),
    .upd_way    (lru_way)
  );

  // NOTE: every output and next-state value gets a default before the case,
  // so no path through the block leaves a signal unassigned (no latches).
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    FillEn     = 1'b0;
    UpdateEn   = 1'b0;
    CacheWay   = 1'b0;
    CacheSet   = '0;
    CacheData  = '0;
    lru_upd    = 1'b0;
    lru_set    = set_in;
    lru_way    = 1'b0;
    unique case (state)
      IDLE: begin
        if (MemWriteM) begin
          stall      = 1'b1;
          state_next = WR_MEM;
        end else if (MemReadM) begin
          if (!(Hit0 || Hit1)) begin
            stall      = 1'b1;
            state_next = RD_MISS;
          end else begin
            lru_upd = 1'b1;
            lru_way = Hit0 ? 1'b0 : 1'b1;
          end
        end
      end
      RD_MISS: begin
        stall = 1'b1;
        if (mem.mem_ready) state_next = FILL;
      end
      FILL: begin
        stall      = 1'b1;
        FillEn     = 1'b1;
        CacheWay   = victim_q;
        CacheSet   = set_q;
        CacheData  = rdata_q;
        lru_upd    = 1'b1;
        lru_set    = set_q;
        lru_way    = victim_q;
        state_next = IDLE;
      end
      WR_MEM: begin
        stall = 1'b1;
        if (mem.mem_ready) begin
          state_next = DONE;
          if (hit0_q || hit1_q) begin
            UpdateEn  = 1'b1;
            CacheWay  = !hit0_q;
            CacheSet  = set_q;
            CacheData = wdata_q;
            lru_upd   = 1'b1;
            lru_set   = set_q;
            lru_way   = !hit0_q;
          end
        end
      end
      // The store is still visible for one cycle; ignore it so it is not replayed.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The IDLE stall term is combinational from the pipeline, so hold it low in reset.
  assign StallM = stall && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      hit0_q        <= 1'b0;
      hit1_q        <= 1'b0;
      victim_q      <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
    end else begin
      state <= state_next;
      if (start_wr || start_rd) addr_q <= ALUResultM;
      if (start_wr) begin
        wdata_q <= WriteDataM;
        hit0_q  <= Hit0;
        hit1_q  <= Hit1;
      end
      if (start_rd) victim_q <= victim;
      if (state == RD_MISS && mem.mem_ready) rdata_q <= mem.mem_rdata;
      // Bus fields load on the entry edge and hold until the ready edge.
      mem.mem_req   <= req_next;
      mem.mem_we    <= (state_next == WR_MEM);
      mem.mem_addr  <= req_next ? word_align((state == IDLE) ? ALUResultM : addr_q) : '0;
      mem.mem_wdata <= (state_next == WR_MEM) ? ((state == IDLE) ? WriteDataM : wdata_q) : '0;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: a transaction-level model predicts every output
// each cycle from the miss/store timelines, plus literal checks that pin the model.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        Hit0, Hit1, Valid0, Valid1;
  logic        StallM, FillEn, UpdateEn, CacheWay;
  logic [1:0]  CacheSet;
  logic [31:0] CacheData;

  cache_if mem_bus ();

  cache_ctrl #(.NUM_SET(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .Hit0       (Hit0),
    .Hit1       (Hit1),
    .Valid0     (Valid0),
    .Valid1     (Valid1),
    .StallM     (StallM),
    .FillEn     (FillEn),
    .UpdateEn   (UpdateEn),
    .CacheWay   (CacheWay),
    .CacheSet   (CacheSet),
    .CacheData  (CacheData),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected outputs for the current cycle, written by the stimulus tasks.
  logic        e_stall, e_fill, e_upd, e_way, e_req, e_we;
  logic [1:0]  e_set;
  logic [31:0] e_data, e_addr, e_wdata;
  logic        chk_en = 1'b0;

  // Reference LRU: index of the least-recently-used way per set.
  int lru_m [4];

  // Event counters and last-strobe capture, used by the literal checks.
  int          stall_cnt = 0, fill_cnt = 0, upd_cnt = 0, wr_cnt = 0;
  logic        last_fill_way, last_upd_way;
  logic [1:0]  last_fill_set;
  logic [31:0] last_fill_data, last_upd_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("StallM",    {31'd0, StallM},          {31'd0, e_stall});
      check("FillEn",    {31'd0, FillEn},          {31'd0, e_fill});
      check("UpdateEn",  {31'd0, UpdateEn},        {31'd0, e_upd});
      check("CacheWay",  {31'd0, CacheWay},        {31'd0, e_way});
      check("CacheSet",  {30'd0, CacheSet},        {30'd0, e_set});
      check("CacheData", CacheData,                e_data);
      check("mem_req",   {31'd0, mem_bus.mem_req}, {31'd0, e_req});
      check("mem_we",    {31'd0, mem_bus.mem_we},  {31'd0, e_we});
      check("mem_addr",  mem_bus.mem_addr,         e_addr);
      check("mem_wdata", mem_bus.mem_wdata,        e_wdata);
    end
  end

  always @(negedge clk) begin
    if (StallM) stall_cnt++;
    if (FillEn) begin
      fill_cnt++;
      last_fill_way  = CacheWay;
      last_fill_set  = CacheSet;
      last_fill_data = CacheData;
    end
    if (UpdateEn) begin
      upd_cnt++;
      last_upd_way  = CacheWay;
      last_upd_data = CacheData;
    end
    if (mem_bus.mem_req && mem_bus.mem_ready && mem_bus.mem_we) wr_cnt++;
  end

  function automatic int set_of(input logic [31:0] a);
    return int'((a >> 2) % 4);
  endfunction

  task automatic clear_exp();
    e_stall = 0; e_fill = 0; e_upd = 0; e_way = 0; e_req = 0; e_we = 0;
    e_set = 0; e_data = 0; e_addr = 0; e_wdata = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_hit(input logic [31:0] a, input logic way);
    MemReadM = 1; MemWriteM = 0; ALUResultM = a;
    Hit0 = (way == 1'b0); Hit1 = (way == 1'b1); Valid0 = 1; Valid1 = 1;
    clear_exp();
    tick();
    lru_m[set_of(a)] = (way == 1'b0) ? 1 : 0;
    MemReadM = 0; Hit0 = 0; Hit1 = 0;
  endtask

  // Miss detected in cycle T, memory ready k cycles after mem_req rises,
  // fill at T+2+k, the replayed load hits at T+3+k.
  task automatic read_miss(input logic [31:0] a, input int k, input logic [31:0] rd,
                           input logic v0, input logic v1);
    int   s;
    logic w;
    s = set_of(a);
    w = !v0 ? 1'b0 : (!v1 ? 1'b1 : (lru_m[s] != 0));
    MemReadM = 1; MemWriteM = 0; ALUResultM = a;
    Hit0 = 0; Hit1 = 0; Valid0 = v0; Valid1 = v1;
    clear_exp(); e_stall = 1;
    tick();
    for (int j = 0; j <= k; j++) begin
      clear_exp(); e_stall = 1; e_req = 1; e_addr = {a[31:2], 2'b00};
      mem_bus.mem_ready = (j == k);
      mem_bus.mem_rdata = (j == k) ? rd : 32'h0BAD_0BAD;
      tick();
    end
    mem_bus.mem_ready = 0; mem_bus.mem_rdata = 32'h0;
    clear_exp(); e_stall = 1; e_fill = 1; e_way = w; e_set = 2'(s); e_data = rd;
    tick();
    lru_m[s] = (w == 1'b0) ? 1 : 0;
    Hit0 = (w == 1'b0); Hit1 = (w == 1'b1);
    if (w == 1'b0) Valid0 = 1; else Valid1 = 1;
    clear_exp();
    tick();
    MemReadM = 0; Hit0 = 0; Hit1 = 0;
  endtask

  // Store detected in T, WR_MEM T+1..T+1+k, DONE T+2+k with the store still asserted.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic h0,
                       input logic h1, input int k, input logic also_read);
    int s;
    s = set_of(a);
    MemWriteM = 1; MemReadM = also_read; ALUResultM = a; WriteDataM = d;
    Hit0 = h0; Hit1 = h1; Valid0 = 1; Valid1 = 1;
    clear_exp(); e_stall = 1;
    tick();
    WriteDataM = 32'hFFFF_0000;
    for (int j = 0; j <= k; j++) begin
      clear_exp(); e_stall = 1; e_req = 1; e_we = 1;
      e_addr = {a[31:2], 2'b00}; e_wdata = d;
      mem_bus.mem_ready = (j == k);
      if (j == k && (h0 || h1)) begin
        e_upd = 1; e_way = h1; e_set = 2'(s); e_data = d;
      end
      tick();
    end
    if (h0 || h1) lru_m[s] = h1 ? 0 : 1;
    mem_bus.mem_ready = 1;
    clear_exp();
    tick();
    MemWriteM = 0; MemReadM = 0; Hit0 = 0; Hit1 = 0; mem_bus.mem_ready = 0;
    clear_exp();
    tick();
  endtask

  int snap_wr, snap_upd, snap_fill;

  initial begin
    rst = 1; MemReadM = 0; MemWriteM = 0; ALUResultM = 0; WriteDataM = 0;
    Hit0 = 0; Hit1 = 0; Valid0 = 0; Valid1 = 0;
    mem_bus.mem_ready = 0; mem_bus.mem_rdata = 0;
    for (int i = 0; i < 4; i++) lru_m[i] = 0;
    clear_exp();
    #2 rst = 0;
    chk_en = 1;
    MemWriteM = 1;
    tick();
    MemWriteM = 0;
    tick();
    rst = 1;
    tick();

    // Cold miss at 0x10, k=2.
    stall_cnt = 0; snap_fill = fill_cnt;
    read_miss(32'h10, 2, 32'hDEAD_BEEF, 0, 0);
    check("cold_stall_cycles", stall_cnt, 5);
    check("cold_fill_count", fill_cnt - snap_fill, 1);
    check("cold_fill_way", {31'd0, last_fill_way}, 0);
    check("cold_fill_set", {30'd0, last_fill_set}, 0);
    check("cold_fill_data", last_fill_data, 32'hDEAD_BEEF);

    // Full set 1 with lru[1]=1: evict way 1, then way 0.
    read_hit(32'h24, 1'b0);
    read_miss(32'h24, 1, 32'hA5A5_0001, 1, 1);
    check("lru_victim_way1", {31'd0, last_fill_way}, 1);
    read_miss(32'h44, 0, 32'h0000_0044, 1, 1);
    check("lru_victim_way0", {31'd0, last_fill_way}, 0);

    // Store hit on way 1, k=0.
    snap_wr = wr_cnt; snap_upd = upd_cnt;
    store(32'h08, 32'h1234, 0, 1, 0, 0);
    check("store_hit_writes", wr_cnt - snap_wr, 1);
    check("store_hit_updates", upd_cnt - snap_upd, 1);
    check("store_hit_way", {31'd0, last_upd_way}, 1);
    check("store_hit_data", last_upd_data, 32'h1234);

    // Store miss in set 2 must leave lru[2]=0; next full-set miss picks way 0.
    snap_wr = wr_cnt; snap_upd = upd_cnt; snap_fill = fill_cnt;
    store(32'h18, 32'h5555_AAAA, 0, 0, 1, 0);
    check("store_miss_writes", wr_cnt - snap_wr, 1);
    check("store_miss_updates", upd_cnt - snap_upd, 0);
    check("store_miss_fills", fill_cnt - snap_fill, 0);
    read_miss(32'h28, 0, 32'h0000_0028, 1, 1);
    check("store_miss_lru", {31'd0, last_fill_way}, 0);

    // Load and store together on a hit address behave as a store.
    snap_wr = wr_cnt;
    store(32'h30, 32'hCAFE_F00D, 1, 0, 1, 1);
    check("rw_as_store_writes", wr_cnt - snap_wr, 1);

    // Reset in the middle of a read miss; lru[1]=1 beforehand.
    read_hit(32'h34, 1'b0);
    MemReadM = 1; ALUResultM = 32'h54; Hit0 = 0; Hit1 = 0; Valid0 = 1; Valid1 = 1;
    clear_exp(); e_stall = 1;
    tick();
    clear_exp(); e_stall = 1; e_req = 1; e_addr = 32'h54;
    tick();
    chk_en = 0;
    #2 rst = 0;
    #1;
    check("rst_mem_req", {31'd0, mem_bus.mem_req}, 0);
    check("rst_stall", {31'd0, StallM}, 0);
    check("rst_fill", {31'd0, FillEn}, 0);
    clear_exp();
    for (int i = 0; i < 4; i++) lru_m[i] = 0;
    chk_en = 1;
    tick();
    MemReadM = 0; mem_bus.mem_ready = 1;
    tick();
    rst = 1; mem_bus.mem_ready = 0;
    snap_fill = fill_cnt;
    for (int i = 0; i < 3; i++) tick();
    check("rst_no_fill", fill_cnt - snap_fill, 0);
    read_miss(32'h54, 0, 32'h0000_0054, 1, 1);
    check("rst_lru_cleared", {31'd0, last_fill_way}, 0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss/refill and write-through sequencer for the 2-way set-associative data cache in the memory stage of the pipelined RISC-V core. It owns the per-set LRU state and chooses the victim way. It stalls the pipeline on read misses and stores, runs a req/ready handshake to main memory, and drives the fill and update strobes of the cache arrays. Write policy is write-through, no-write-allocate. Lines are one word.

## Interface
Parameters:
- NUM_SET, 4, number of sets (power of two ≥2); SET_W = $clog2(NUM_SET)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- MemReadM  in  1  load in memory stage
- MemWriteM  in  1  store in memory stage
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data
- Hit0, Hit1  in  1 each  tag-compare hit for addressed set, way 0 / way 1
- Valid0, Valid1  in  1 each  valid bits of addressed set
- StallM  out  1  freeze pipeline
- FillEn  out  1  write tag/data/valid into cache array
- UpdateEn  out  1  overwrite data of the hitting way (store hit)
- CacheWay  out  1  way targeted by FillEn/UpdateEn
- CacheSet  out  SET_W  set targeted
- CacheData  out  32  data for FillEn/UpdateEn
- mem_req  out  1  memory transaction valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts/completes the transaction this cycle
- mem_rdata  in  32  read data, valid when mem_ready=1 on a read

## Operation
- States: IDLE, RD_MISS, FILL, WR_MEM, DONE.
- IDLE:
  - MemWriteM=1 (wins over MemReadM): latch addr, data, Hit0/Hit1; StallM=1; go to WR_MEM.
  - Else MemReadM=1 and !(Hit0|Hit1): latch addr; latch victim; StallM=1; go to RD_MISS.
  - Read hit: StallM=0; LRU update.
  - No request: idle.
- Victim: Valid0=0 → way 0; else Valid1=0 → way 1; else lru[set].
- lru[set] = index of least-recently-used way. On read hit, fill or store hit to way w: lru[set] <= ~w. Store miss leaves it unchanged.
- RD_MISS: mem_req=1, mem_we=0, StallM=1. On mem_ready=1: capture mem_rdata; go to FILL.
- FILL: FillEn=1 with latched victim/set and captured data; StallM=1. LRU update; go to IDLE. The re-evaluated access then hits with no stall.
- WR_MEM: mem_req=1, mem_we=1, StallM=1. On mem_ready=1: if the latched hit is set, UpdateEn=1 for that way in this same cycle and LRU is updated; go to DONE.
- DONE: StallM=0; all requests ignored for this cycle, so the store completes exactly once. Next state is IDLE.
- mem_ready while mem_req=0: ignored.
- Memory outputs and cache strobes are held stable and are 0 outside the states listed above.

## Timing
- rst low (any time, including mid-transaction): state=IDLE; lru all 0; latches cleared; all outputs 0 while rst low. An in-flight memory transaction is abandoned.
- Read hit: 0 stall cycles.
- Read miss, mem_ready k cycles after mem_req rises (k≥0):
  - Detect cycle T.
  - RD_MISS covers T+1 … T+1+k.
  - FILL at T+2+k.
  - Hit in IDLE at T+3+k.
  - StallM high for k+3 cycles.
- Store: detect T; WR_MEM T+1 … T+1+k; DONE T+2+k. StallM high for k+2 cycles.
- mem_req, mem_addr and mem_wdata are registered. They are constant from the first RD_MISS/WR_MEM cycle until the mem_ready edge.
- FillEn and UpdateEn are single-cycle pulses.

## Structure
- Package cache_pkg holds:
  - state enum ctrl_state_t;
  - NUM_WAY=2;
  - address field helpers (set index, tag, word alignment) shared with the cache array.
- Sub-module cache_lru (parameter NUM_SET) contains:
  - the lru bit array;
  - an update port (set, used way);
  - the combinational victim select from Valid0/Valid1.

## Test plan
- Reset, then a load at 0x10 with Valid0=Valid1=0 and memory returning 0xDEADBEEF at k=2:
  - StallM high 5 cycles;
  - FillEn with way 0, set 0, data 0xDEADBEEF;
  - mem_addr=0x10 for the whole transaction.
- Set 1 full and lru[1]=1; load miss at 0x24 → fill goes to way 1, then lru[1]=0. Next miss at 0x44 fills way 0.
- Store hit on way 1 at 0x08, data 0x1234, k=0:
  - mem_we=1;
  - UpdateEn with way 1 and data 0x1234 in the mem_ready cycle;
  - exactly one memory write, even though MemWriteM stays high through DONE.
- Store miss: mem write occurs; no UpdateEn/FillEn; lru unchanged.
- MemReadM=MemWriteM=1 on a hit address → treated as a store (WR_MEM entered).
- Assert rst during RD_MISS with mem_req=1:
  - mem_req, StallM and FillEn go to 0 immediately;
  - no fill after release;
  - lru all 0.
